// File: rtl/sd_host_pkg.sv
// rtl/sd_host_pkg.sv - shared SD host types and constants
package sd_host_pkg;

  // SD_CLK generator phase
  typedef enum logic [1:0] {
    STOPPED  = 2'd0,
    RUN_LOW  = 2'd1,
    RUN_HIGH = 2'd2
  } sd_clk_state_e;

  // Identification-mode half-period in ex_clk cycles
  localparam int SD_DEFAULT_DIV = 2;

endpackage

// File: rtl/sd_clk_gen.sv
// rtl/sd_clk_gen.sv - programmable SD_CLK generator with glitch-free gating and edge strobes
module sd_clk_gen
  import sd_host_pkg::*;
#(
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = SD_DEFAULT_DIV
) (
  input  logic             ex_clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_load,
  output logic             div_ack,
  input  logic             clk_en,
  output logic             sd_clk,
  output logic             sd_clk_rise,
  output logic             sd_clk_fall,
  output logic             clk_running,
  output logic [DIV_W-1:0] cur_div
);

  localparam logic [DIV_W-1:0] ONE      = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DEFAULT_DIV);

  sd_clk_state_e    state, state_nx;
  logic [DIV_W-1:0] cnt, cnt_nx;
  logic [DIV_W-1:0] pend_div;
  logic             pend_vld;
  logic             safe_now;
  logic             fall_edge;
  logic             apply;
  logic             sd_clk_nx;
  logic [DIV_W-1:0] low_m1;
  logic [DIV_W-1:0] high_m1;

  // Safe points, divisor selection and next phase/count
  always_comb begin
    safe_now  = (state == STOPPED) || ((state == RUN_LOW) && (cnt == '0));
    high_m1   = cur_div - ONE;
    // A divisor applied at the start of a low phase governs that whole phase
    low_m1    = (pend_vld && safe_now) ? (pend_div - ONE) : high_m1;
    fall_edge = (state == RUN_HIGH) && (cnt >= high_m1);
    apply     = pend_vld && (safe_now || fall_edge);

    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      STOPPED: begin
        cnt_nx = '0;
        if (clk_en) state_nx = RUN_LOW;
      end
      RUN_LOW: begin
        if (!clk_en) begin
          // Stopping during low just stretches the low level; no glitch
          state_nx = STOPPED;
          cnt_nx   = '0;
        end else if (cnt >= low_m1) begin
          state_nx = RUN_HIGH;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + ONE;
        end
      end
      RUN_HIGH: begin
        // High phase always runs to completion so SD_CLK is never truncated
        if (cnt >= high_m1) begin
          state_nx = RUN_LOW;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + ONE;
        end
      end
      default: begin
        state_nx = STOPPED;
        cnt_nx   = '0;
      end
    endcase
    sd_clk_nx = (state_nx == RUN_HIGH);
  end

  // Phase state, counter, registered clock/strobes and divisor registers
  always_ff @(posedge ex_clk) begin
    if (reset) begin
      state       <= STOPPED;
      cnt         <= '0;
      sd_clk      <= 1'b0;
      sd_clk_rise <= 1'b0;
      sd_clk_fall <= 1'b0;
      clk_running <= 1'b0;
      div_ack     <= 1'b0;
      cur_div     <= DIV_RST;
      pend_div    <= ONE;
      pend_vld    <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      sd_clk      <= sd_clk_nx;
      sd_clk_rise <= sd_clk_nx & ~sd_clk;
      sd_clk_fall <= ~sd_clk_nx & sd_clk;
      clk_running <= (state_nx != STOPPED);
      div_ack     <= apply;
      if (apply) cur_div <= pend_div;
      // A load always lands in pending; it is applied at a later safe point
      if (div_load) begin
        pend_div <= (div_in == '0) ? ONE : div_in;
        pend_vld <= 1'b1;
      end else if (apply) begin
        pend_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sd_clk_gen.sv
// tb/tb_sd_clk_gen.sv - directed self-checking bench for sd_clk_gen
module tb_sd_clk_gen;

  logic        ex_clk = 1'b0;
  logic        reset;
  logic [15:0] div_in;
  logic        div_load;
  logic        div_ack;
  logic        clk_en;
  logic        sd_clk;
  logic        sd_clk_rise;
  logic        sd_clk_fall;
  logic        clk_running;
  logic [15:0] cur_div;

  int checks = 0;
  int failures = 0;

  sd_clk_gen #(.DIV_W(16)) dut (
    .ex_clk      (ex_clk),
    .reset       (reset),
    .div_in      (div_in),
    .div_load    (div_load),
    .div_ack     (div_ack),
    .clk_en      (clk_en),
    .sd_clk      (sd_clk),
    .sd_clk_rise (sd_clk_rise),
    .sd_clk_fall (sd_clk_fall),
    .clk_running (clk_running),
    .cur_div     (cur_div)
  );

  always #5 ex_clk = ~ex_clk;

  // advance one cycle; inputs are driven and outputs sampled at negedge
  task automatic tick();
    @(posedge ex_clk);
    @(negedge ex_clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; clk_en = 1'b0; div_load = 1'b0; div_in = 16'd0;
    @(negedge ex_clk);
    tick(); tick();
    reset = 1'b0;
    checks++; if (sd_clk !== 1'b0) begin failures++; $display("FAIL reset_sd_clk got=%0b exp=0", sd_clk); end
    checks++; if (sd_clk_rise !== 1'b0) begin failures++; $display("FAIL reset_rise got=%0b exp=0", sd_clk_rise); end
    checks++; if (sd_clk_fall !== 1'b0) begin failures++; $display("FAIL reset_fall got=%0b exp=0", sd_clk_fall); end
    checks++; if (div_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%0b exp=0", div_ack); end
    checks++; if (clk_running !== 1'b0) begin failures++; $display("FAIL reset_running got=%0b exp=0", clk_running); end
    checks++; if (cur_div !== 16'd2) begin failures++; $display("FAIL reset_cur_div got=%0d exp=2", cur_div); end
  endtask

  task automatic test_start_n2();
    int cyc;
    int rises;
    int falls;
    logic exp_clk, exp_rise, exp_fall;
    clk_en = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
      if (cyc == 1) begin
        checks++; if (clk_running !== 1'b1) begin failures++; $display("FAIL start_running got=%0b exp=1", clk_running); end
      end
    end while (sd_clk_rise !== 1'b1 && cyc < 20);
    checks++; if (cyc != 3) begin failures++; $display("FAIL start_latency got=%0d exp=3", cyc); end
    rises = 0; falls = 0;
    for (int i = 0; i < 8; i++) begin
      exp_clk  = ((i % 4) < 2);
      exp_rise = ((i % 4) == 0);
      exp_fall = ((i % 4) == 2);
      checks++; if (sd_clk !== exp_clk) begin failures++; $display("FAIL n2_sd_clk[%0d] got=%0b exp=%0b", i, sd_clk, exp_clk); end
      checks++; if (sd_clk_rise !== exp_rise) begin failures++; $display("FAIL n2_rise[%0d] got=%0b exp=%0b", i, sd_clk_rise, exp_rise); end
      checks++; if (sd_clk_fall !== exp_fall) begin failures++; $display("FAIL n2_fall[%0d] got=%0b exp=%0b", i, sd_clk_fall, exp_fall); end
      if (sd_clk_rise === 1'b1) rises++;
      if (sd_clk_fall === 1'b1) falls++;
      tick();
    end
    checks++; if (rises != 2 || falls != 2) begin failures++; $display("FAIL n2_strobe_count got=%0d/%0d exp=2/2", rises, falls); end
  endtask

  task automatic test_div_mid_high();
    logic exp_clk, exp_fall;
    checks++; if (sd_clk !== 1'b1) begin failures++; $display("FAIL midhigh_pre got=%0b exp=1", sd_clk); end
    div_in = 16'd5; div_load = 1'b1;
    tick();
    div_load = 1'b0;
    checks++; if (sd_clk !== 1'b1) begin failures++; $display("FAIL midhigh_still_high got=%0b exp=1", sd_clk); end
    checks++; if (div_ack !== 1'b0) begin failures++; $display("FAIL midhigh_early_ack got=%0b exp=0", div_ack); end
    tick();
    checks++; if (div_ack !== 1'b1) begin failures++; $display("FAIL midhigh_ack_on_fall got=%0b exp=1", div_ack); end
    checks++; if (cur_div !== 16'd5) begin failures++; $display("FAIL midhigh_cur_div got=%0d exp=5", cur_div); end
    for (int i = 0; i <= 10; i++) begin
      exp_clk  = (i >= 5 && i < 10);
      exp_fall = (i == 0 || i == 10);
      checks++; if (sd_clk !== exp_clk) begin failures++; $display("FAIL n5_sd_clk[%0d] got=%0b exp=%0b", i, sd_clk, exp_clk); end
      checks++; if (sd_clk_fall !== exp_fall) begin failures++; $display("FAIL n5_fall[%0d] got=%0b exp=%0b", i, sd_clk_fall, exp_fall); end
      if (i == 1) begin
        checks++; if (div_ack !== 1'b0) begin failures++; $display("FAIL n5_ack_single got=%0b exp=0", div_ack); end
      end
      if (i < 10) tick();
    end
  endtask

  task automatic test_double_load();
    int acks;
    int ack_on_fall;
    tick();
    div_in = 16'd7; div_load = 1'b1;
    tick();
    div_in = 16'd3;
    tick();
    div_load = 1'b0;
    acks = 0; ack_on_fall = 0;
    for (int i = 0; i < 30; i++) begin
      if (div_ack === 1'b1) begin
        acks++;
        if (sd_clk_fall === 1'b1) ack_on_fall++;
      end
      tick();
    end
    checks++; if (acks != 1) begin failures++; $display("FAIL dbl_ack_count got=%0d exp=1", acks); end
    checks++; if (ack_on_fall != 1) begin failures++; $display("FAIL dbl_ack_on_fall got=%0d exp=1", ack_on_fall); end
    checks++; if (cur_div !== 16'd3) begin failures++; $display("FAIL dbl_cur_div got=%0d exp=3", cur_div); end
  endtask

  task automatic test_stop_n4();
    int g;
    int hi;
    int rises;
    div_in = 16'd4; div_load = 1'b1;
    tick();
    div_load = 1'b0;
    g = 0;
    while (div_ack !== 1'b1 && g < 20) begin tick(); g++; end
    checks++; if (div_ack !== 1'b1) begin failures++; $display("FAIL stop_ack_wait got=%0b exp=1", div_ack); end
    g = 0;
    while (sd_clk_rise !== 1'b1 && g < 20) begin tick(); g++; end
    checks++; if (sd_clk_rise !== 1'b1) begin failures++; $display("FAIL stop_rise_wait got=%0b exp=1", sd_clk_rise); end
    hi = 0; g = 0;
    while (sd_clk === 1'b1 && g < 10) begin
      hi++;
      tick();
      if (hi == 1) clk_en = 1'b0;
      g++;
    end
    checks++; if (hi != 4) begin failures++; $display("FAIL stop_high_len got=%0d exp=4", hi); end
    checks++; if (sd_clk_fall !== 1'b1) begin failures++; $display("FAIL stop_fall got=%0b exp=1", sd_clk_fall); end
    checks++; if (clk_running !== 1'b1) begin failures++; $display("FAIL stop_running_at_fall got=%0b exp=1", clk_running); end
    tick();
    checks++; if (clk_running !== 1'b0) begin failures++; $display("FAIL stop_running_after got=%0b exp=0", clk_running); end
    rises = 0;
    for (int i = 0; i < 10; i++) begin
      if (sd_clk_rise === 1'b1 || sd_clk === 1'b1) rises++;
      tick();
    end
    checks++; if (rises != 0) begin failures++; $display("FAIL stop_no_rise got=%0d exp=0", rises); end
  endtask

  task automatic test_div_zero_stopped();
    logic exp_clk;
    div_in = 16'd0; div_load = 1'b1;
    tick();
    div_load = 1'b0;
    checks++; if (div_ack !== 1'b0) begin failures++; $display("FAIL zero_ack_same got=%0b exp=0", div_ack); end
    tick();
    checks++; if (div_ack !== 1'b1) begin failures++; $display("FAIL zero_ack_next got=%0b exp=1", div_ack); end
    checks++; if (cur_div !== 16'd1) begin failures++; $display("FAIL zero_cur_div got=%0d exp=1", cur_div); end
    tick();
    checks++; if (div_ack !== 1'b0) begin failures++; $display("FAIL zero_ack_pulse got=%0b exp=0", div_ack); end
    clk_en = 1'b1;
    tick();
    checks++; if (clk_running !== 1'b1 || sd_clk !== 1'b0) begin failures++; $display("FAIL zero_start got=%0b%0b exp=10", clk_running, sd_clk); end
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_clk = ((i % 2) == 0);
      checks++; if (sd_clk !== exp_clk) begin failures++; $display("FAIL n1_sd_clk[%0d] got=%0b exp=%0b", i, sd_clk, exp_clk); end
      checks++; if (sd_clk_rise !== exp_clk) begin failures++; $display("FAIL n1_rise[%0d] got=%0b exp=%0b", i, sd_clk_rise, exp_clk); end
    end
  endtask

  task automatic test_reset_mid_high();
    int g;
    int acks;
    div_in = 16'd4; div_load = 1'b1;
    tick();
    div_load = 1'b0;
    g = 0;
    while (div_ack !== 1'b1 && g < 20) begin tick(); g++; end
    g = 0;
    while (sd_clk_rise !== 1'b1 && g < 20) begin tick(); g++; end
    checks++; if (sd_clk !== 1'b1) begin failures++; $display("FAIL rst_pre_high got=%0b exp=1", sd_clk); end
    div_in = 16'd9; div_load = 1'b1;
    tick();
    div_load = 1'b0;
    reset = 1'b1; clk_en = 1'b0;
    tick();
    reset = 1'b0;
    checks++; if (sd_clk !== 1'b0) begin failures++; $display("FAIL rst_sd_clk got=%0b exp=0", sd_clk); end
    checks++; if (cur_div !== 16'd2) begin failures++; $display("FAIL rst_cur_div got=%0d exp=2", cur_div); end
    checks++; if (div_ack !== 1'b0) begin failures++; $display("FAIL rst_ack got=%0b exp=0", div_ack); end
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (div_ack === 1'b1) acks++;
    end
    checks++; if (acks != 0) begin failures++; $display("FAIL rst_pending_cleared got=%0d exp=0", acks); end
    checks++; if (cur_div !== 16'd2) begin failures++; $display("FAIL rst_cur_div_hold got=%0d exp=2", cur_div); end
  endtask

  initial begin
    test_reset();
    test_start_n2();
    test_div_mid_high();
    test_double_load();
    test_stop_n4();
    test_div_zero_stopped();
    test_reset_mid_high();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sd_clk_gen.md
# sd_clk_gen

- Parametrised SD_CLK generator; successor to the fixed half-period counter plus divisor mux at the top of the SD host controller.
- Derives SD_CLK from `ex_clk` with a runtime-programmable divisor that is applied only at a safe low-phase boundary.
- Gates SD_CLK cleanly on request, never producing a truncated high phase.
- Issues single-cycle rise/fall strobes so `sd_send`, `sd_receive` and `sd_fsm` can sample and drive in the `ex_clk` domain without using SD_CLK as a clock.

## Interface
Parameters:
- `DIV_W`, 16, width of the half-period divisor.
- `DEFAULT_DIV`, 2, half-period (in `ex_clk` cycles) after reset; identification-mode rate.

Ports:
- `ex_clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `div_in`  in  DIV_W  requested half-period N, in `ex_clk` cycles; 0 is treated as 1.
- `div_load`  in  1  one-cycle pulse; captures `div_in` as pending divisor.
- `div_ack`  out  1  one-cycle pulse when the pending divisor becomes active.
- `clk_en`  in  1  level; 1 = run SD_CLK, 0 = stop with SD_CLK low.
- `sd_clk`  out  1  registered SD_CLK; period 2N `ex_clk` cycles, 50% duty.
- `sd_clk_rise`  out  1  high for exactly the `ex_clk` cycle in which `sd_clk` is 1 after being 0.
- `sd_clk_fall`  out  1  high for exactly the cycle in which `sd_clk` is 0 after being 1.
- `clk_running`  out  1  1 while SD_CLK is toggling (state not STOPPED).
- `cur_div`  out  DIV_W  active half-period.

## Operation
- States:
  - STOPPED: `sd_clk`=0, counter held at 0.
  - RUN_LOW: `sd_clk`=0, counting.
  - RUN_HIGH: `sd_clk`=1, counting.
- STOPPED -> RUN_LOW when `clk_en`=1.
- RUN_LOW -> RUN_HIGH when cnt==N-1 and `clk_en`=1; cnt resets to 0.
- RUN_LOW -> STOPPED when `clk_en`=0, at any count; the low phase simply extends.
- RUN_HIGH -> RUN_LOW when cnt==N-1; cnt resets to 0. The high phase always completes, regardless of `clk_en`.
- Divisor update:
  - `div_load` writes the pending register and sets its valid flag. A later load before apply overwrites it (last wins, single `div_ack`).
  - Pending is applied at a safe point: on the cycle `sd_clk` falls, or on any cycle in STOPPED or RUN_LOW with cnt==0.
  - On apply, `cur_div` updates and `div_ack` pulses on the same cycle.
  - `div_in`=0 is stored as 1. N=1 gives period 2 (`ex_clk`/2).
- Counter width DIV_W; compare against N-1 computed on the stored value; no wrap beyond N-1.

## Timing
- Reset values: `sd_clk`=0, `sd_clk_rise`=0, `sd_clk_fall`=0, `div_ack`=0, `clk_running`=0, `cur_div`=DEFAULT_DIV, pending valid=0, state STOPPED.
- Reset mid-high phase forces `sd_clk` low on the next edge; this truncated pulse is accepted.
- Start latency: `clk_en` sampled 1 in STOPPED -> `clk_running`=1 next cycle -> first `sd_clk_rise` N cycles after that.
- All outputs are registered; strobes coincide with the `sd_clk` edge they mark.
- `div_load` in a safe-point cycle is captured, and applies at the next safe point, never the same cycle.
- `div_load` in STOPPED: `div_ack` 1 cycle later.
- `clk_en` falls in RUN_HIGH at cnt==N-1: fall occurs normally, then STOPPED. No further rise.
- `clk_en` toggled 0->1 within one low phase: no glitch; low phase restarts count from 0.
- New divisor takes effect for the entire low phase following the fall at which it was applied.

## Structure
- Shared package `sd_host_pkg`: state encodings (STOPPED, RUN_LOW, RUN_HIGH) and `SD_DEFAULT_DIV`=2. Top-level `DEFAULT_DIV` is bound to this constant.
- No sub-module: counter, FSM and pending register are inline. Top level instantiates `sd_clk_gen` in place of the current divider and its fixed-2 mux. `clk_div_count_generator` drives `div_in`/`div_load`.

## Test plan
- Reset then `clk_en`=1, N=2 -> first rise 3 cycles after `clk_en` sampled; period 4, duty 2/2; one rise and one fall strobe per period.
- `div_load` with `div_in`=5 mid-high phase (N=2) -> high phase completes at 2 cycles; `div_ack` on the fall cycle; then low and high phases of 5 cycles each; `cur_div`=5.
- Two `div_load`s (7 then 3) before a safe point -> single `div_ack`; `cur_div`=3.
- `clk_en`=0 one cycle into high phase (N=4) -> high lasts 4 cycles; `sd_clk` held 0; `clk_running`=0 the cycle after fall; no rise strobes.
- `div_in`=0 loaded while STOPPED -> `div_ack` next cycle; `cur_div`=1; on enable, `sd_clk` toggles every cycle (period 2).
- `reset` asserted mid-high with pending divisor -> next cycle `sd_clk`=0, `cur_div`=2, pending cleared, no `div_ack`.
